i4003_loader: RTL and testbench
===============================

I4003_LOADER -- requirements
Module: i4003_loader

Interface
REQ-001 SHALL have parameter NBITS, default 10, giving the word length (10 = one shift register, 20 = two cascaded).
REQ-002 SHALL have parameter DIV, default 4, giving clk cycles per sr_cp half-period; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port wr_valid, input, 1: wr_data is offered.
REQ-006 SHALL have port wr_ready, output, 1: loader is idle and can accept a word.
REQ-007 SHALL have port wr_data, input, NBITS: the parallel word to load.
REQ-008 SHALL have port sr_cp, output, 1: shift clock to the shift register's cp input.
REQ-009 SHALL have port sr_data, output, 1: serial data to the shift register's data input.
REQ-010 SHALL have port sr_e, output, 1: output enable to the shift register's e input.
REQ-011 SHALL have port sr_sout, input, 1: serial output returned from the last shift register.
REQ-012 SHALL have port busy, output, 1: a load is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a load completes.
REQ-014 SHALL have port err, output, 1: sticky loopback mismatch flag.

Function
REQ-015 SHALL accept a word on the clk edge where wr_valid and wr_ready are both 1 (cycle T), capture wr_data, and deassert wr_ready from T+1.
REQ-016 SHALL use FSM states IDLE, LOW, HIGH and FIN: IDLE->LOW on accept; LOW->HIGH after DIV cycles; HIGH->LOW after DIV cycles if bits remain, else HIGH->FIN; FIN->IDLE after 1 cycle.
REQ-017 SHALL send MSB first: bit index k (0..NBITS-1) drives sr_data = word[NBITS-1-k], so that after the load the shift register's parallel output bit i equals wr_data[i].
REQ-018 SHALL change sr_data only on entry to LOW, and SHALL hold it stable throughout that LOW phase and the following HIGH phase.
REQ-019 SHALL drive sr_cp=0 in IDLE, LOW and FIN, and sr_cp=1 in HIGH; the shift register is therefore clocked exactly NBITS times per load.
REQ-020 SHALL drive sr_e=0 from T+1 until FIN, set sr_e=1 in FIN, and hold sr_e=1 in IDLE until the next accept; outputs stay disabled while shifting.
REQ-021 SHALL assert busy for states LOW, HIGH and FIN, and SHALL pulse done for exactly the FIN cycle, T+2*DIV*NBITS+1.
REQ-022 SHALL assert wr_ready in IDLE only; wr_valid is ignored while busy is 1, and a new word is accepted on the first IDLE cycle after FIN.
REQ-023 SHALL use counters wide enough for DIV and NBITS, with no wrap-around inside a load.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-load, immediately force state IDLE and the outputs sr_cp=0, sr_data=0, sr_e=0, busy=0, done=0, err=0 and wr_ready=1 (wr_ready=1 from the first clk edge after release), and clear the shadow word to 0.
REQ-025 SHALL leave the shift register contents untouched by reset; an aborted load leaves a partial word behind that the next full load overwrites.

Configuration
REQ-026 SHALL, when macro I4003_LOADER_LOOPBACK_CHECK_EN is defined, keep a shadow copy of the last completed word (0 after reset), sample sr_sout in the last clk cycle of the LOW phase for bit k, compare it with shadow[NBITS-1-k], and set err=1 on any mismatch; err is sticky until reset.
REQ-027 SHALL update the shadow copy in FIN when the check is enabled.
REQ-028 SHALL, without I4003_LOADER_LOOPBACK_CHECK_EN, tie err to 0, ignore sr_sout, and implement no shadow register.

Verification
REQ-029 SHALL verify a basic load: NBITS=10, DIV=2, load 10'h2A5 -> 10 sr_cp pulses of 2 high/2 low cycles, register model parallel output 10'h2A5, done at T+41, sr_e low T+1..T+40 and high at T+41.
REQ-030 SHALL verify back-to-back loads: wr_valid held high with 10'h3FF then 10'h000 -> second accept on the cycle after done, with no sr_cp pulse between the two loads.
REQ-031 SHALL verify reset mid-load: rst_n low after pulse 5 -> sr_cp, sr_e and busy go 0 immediately, wr_ready=1 after release; a following load of 10'h155 yields 10'h155.
REQ-032 SHALL verify a clean loopback (macro defined): loads 10'h1C3 then 10'h0F0 through the register model -> err stays 0.
REQ-033 SHALL verify a loopback fault (macro defined): sr_sout forced to 1 during the second load after 10'h000 -> err=1 and it stays 1 through later loads until rst_n=0.
REQ-034 SHALL verify the cascade: NBITS=20, DIV=1, load 20'hABCDE into two chained register models -> the combined parallel output is 20'hABCDE and done arrives at T+41.

Source files
------------

// File: rtl/i4003_loader.sv
// -----------------------------------------------------------------------------
// i4003_loader
//   Serialises a parallel word into one (NBITS=10) or two cascaded (NBITS=20)
//   4003-style shift registers. Each bit is presented on sr_data for a LOW phase
//   of DIV clk cycles, then clocked in by a HIGH phase of DIV cycles on sr_cp.
//   The MSB is sent first, so after the load the register chain's parallel
//   output bit i equals wr_data[i]. sr_e is held low while shifting and raised
//   once the word is complete.
//
//   Optional feature: define I4003_LOADER_LOOPBACK_CHECK_EN to compare the
//   returned serial stream (sr_sout) against a shadow of the last completed
//   word and raise a sticky err on mismatch. Without it err is tied to 0.
//
// Parameters
//   NBITS    word length in bits (>= 2)
//   DIV      clk cycles per sr_cp half-period (1..255)
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   wr_valid / wr_ready / wr_data   word hand-off, accepted when both high
//   sr_cp / sr_data / sr_e          shift clock, serial data, output enable
//   sr_sout  serial output returned from the last register in the chain
//   busy     load in progress (LOW, HIGH, FIN)
//   done     one-cycle pulse in the FIN cycle
//   err      sticky loopback mismatch flag
// -----------------------------------------------------------------------------
module i4003_loader #(
    parameter int unsigned NBITS = 10,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [NBITS-1:0] wr_data,
    output logic             sr_cp,
    output logic             sr_data,
    output logic             sr_e,
    input  logic             sr_sout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned   BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_div_cnt;
    logic [DW-1:0]    w_div_cnt_nxt;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_cnt_nxt;
    logic [NBITS-1:0] r_word;
    logic             r_sr_cp;
    logic             r_sr_data;
    logic             r_sr_e;
    logic             w_accept;
    logic             w_phase_end;
    logic             w_to_low;

    assign w_accept    = wr_valid && (r_state == IDLE);
    assign w_phase_end = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_to_low      = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_valid) begin
                    w_state_nxt   = LOW;
                    w_div_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                end
            end
            LOW: begin
                if (w_phase_end) begin
                    w_state_nxt   = HIGH;
                    w_div_cnt_nxt = '0;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (w_phase_end) begin
                    w_div_cnt_nxt = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt   = LOW;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_to_low      = 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_word is rotated once per bit sent (once at accept, once per HIGH->LOW),
    // so its MSB is always the next bit and it is back to the original word
    // by the FIN cycle, where the shadow copy can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_word    <= '0;
            r_sr_cp   <= 1'b0;
            r_sr_data <= 1'b0;
            r_sr_e    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            // Registered from next state so the shift clock is glitch-free.
            r_sr_cp   <= (w_state_nxt == HIGH);
            if (w_accept) begin
                r_sr_data <= wr_data[NBITS-1];
                r_word    <= {wr_data[NBITS-2:0], wr_data[NBITS-1]};
                r_sr_e    <= 1'b0;
            end else if (w_to_low) begin
                r_sr_data <= r_word[NBITS-1];
                r_word    <= {r_word[NBITS-2:0], r_word[NBITS-1]};
            end
            if (w_state_nxt == FIN) begin
                r_sr_e <= 1'b1;
            end
        end
    end

`ifdef I4003_LOADER_LOOPBACK_CHECK_EN
    // Before pulse k the chain's serial output still carries bit NBITS-1-k of
    // the previously completed word, which the shadow holds.
    logic [NBITS-1:0] r_shadow;
    logic             r_err;
    logic [BW-1:0]    w_chk_idx;

    assign w_chk_idx = BIT_LAST - r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == FIN) begin
                r_shadow <= r_word;
            end
            if ((r_state == LOW) && w_phase_end && (sr_sout != r_shadow[w_chk_idx])) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_sout;
    assign w_unused_sout = sr_sout;
    assign err           = 1'b0;
`endif

    assign wr_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == FIN);
    assign sr_cp    = r_sr_cp;
    assign sr_data  = r_sr_data;
    assign sr_e     = r_sr_e;

endmodule

// File: tb/tb_i4003_loader.sv
// -----------------------------------------------------------------------------
// tb_i4003_loader
//   Drives a 10-bit/DIV=2 loader into a behavioural shift register and a
//   20-bit/DIV=1 loader into two chained 10-bit registers, and checks latency,
//   pulse counts, enable behaviour, reset and the loopback flag.
// -----------------------------------------------------------------------------
module tb_i4003_loader;

`ifdef I4003_LOADER_LOOPBACK_CHECK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [9:0]  a_data = '0;
    logic        a_cp, a_sd, a_e, a_sout, a_busy, a_done, a_err;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [19:0] b_data = '0;
    logic        b_cp, b_sd, b_e, b_sout, b_busy, b_done, b_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    i4003_loader #(.NBITS(10), .DIV(2)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (a_valid),
        .wr_ready (a_ready),
        .wr_data  (a_data),
        .sr_cp    (a_cp),
        .sr_data  (a_sd),
        .sr_e     (a_e),
        .sr_sout  (a_sout),
        .busy     (a_busy),
        .done     (a_done),
        .err      (a_err)
    );

    i4003_loader #(.NBITS(20), .DIV(1)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (b_valid),
        .wr_ready (b_ready),
        .wr_data  (b_data),
        .sr_cp    (b_cp),
        .sr_data  (b_sd),
        .sr_e     (b_e),
        .sr_sout  (b_sout),
        .busy     (b_busy),
        .done     (b_done),
        .err      (b_err)
    );

    // Behavioural shift registers: data enters bit 0, serial out is bit 9.
    logic [9:0] a_q = '0;
    int         a_pulses = 0;
    logic       a_force = 1'b0;
    always @(posedge a_cp) begin
        a_q      <= {a_q[8:0], a_sd};
        a_pulses <= a_pulses + 1;
    end
    assign a_sout = a_force ? 1'b1 : a_q[9];

    logic [9:0] b_q1 = '0;
    logic [9:0] b_q2 = '0;
    int         b_pulses = 0;
    always @(posedge b_cp) begin
        b_q1     <= {b_q1[8:0], b_sd};
        b_q2     <= {b_q2[8:0], b_q1[9]};
        b_pulses <= b_pulses + 1;
    end
    assign b_sout = b_q2[9];

    // Expected loopback state for DUT A.
    logic [9:0] a_shadow = '0;
    logic       a_err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Offer w and return at the negedge of cycle T+1.
    task automatic start_a(input logic [9:0] w, input bit keep_valid);
        int k;
        a_valid = 1'b1;
        a_data  = w;
        k = 0;
        while (!a_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", a_ready, 1);
        @(negedge clk);
        if (!keep_valid) a_valid = 1'b0;
    endtask

    // Observe cycles T+1..T+41 of a load of w; return at the negedge of T+41.
    task automatic finish_a(input logic [9:0] w);
        logic [9:0] old;
        logic [9:0] seen;
        int done_at, done_cnt, cp_cycles, rises, e_bad, d_bad;
        logic prev_cp, prev_d;
        old = a_q;
        done_at = 0; done_cnt = 0; cp_cycles = 0; rises = 0; e_bad = 0; d_bad = 0;
        prev_cp = 1'b0;
        prev_d  = a_sd;
        check("ready_low_after_accept", a_ready, 0);
        for (int n = 1; n <= 41; n++) begin
            if (a_done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (a_cp) cp_cycles++;
            if (a_cp && !prev_cp) rises++;
            if (n <= 40 && (a_e || !a_busy)) e_bad++;
            if (n > 1 && a_sd != prev_d && !prev_cp) d_bad++;
            prev_cp = a_cp;
            prev_d  = a_sd;
            if (n < 41) @(negedge clk);
        end
        check("done_cycle", done_at, 41);
        check("done_count", done_cnt, 1);
        check("cp_rises", rises, 10);
        check("cp_high_cycles", cp_cycles, 20);
        check("sr_e_low_while_shifting", e_bad, 0);
        check("sr_data_stable", d_bad, 0);
        check("sr_e_high_in_fin", a_e, 1);
        check("cp_low_in_fin", a_cp, 0);
        check("model_word", a_q, w);
        seen = a_force ? 10'h3FF : old;
        if (LB && seen != a_shadow) a_err_exp = 1'b1;
        a_shadow = w;
        check("err_flag", a_err, a_err_exp);
    endtask

    task automatic load_a(input logic [9:0] w);
        start_a(w, 1'b0);
        finish_a(w);
    endtask

    typedef struct {
        logic [9:0] word;
        logic [9:0] exp_q;
    } vec_t;

    vec_t       tbl[8];
    logic [9:0] w_mid;
    logic [9:0] old_mid;
    logic [9:0] r_w;
    int         p0;
    int         k;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{10'h2A5, 10'h2A5};
        tbl[1] = '{10'h1C3, 10'h1C3};
        tbl[2] = '{10'h0F0, 10'h0F0};
        tbl[3] = '{10'h3FF, 10'h3FF};
        tbl[4] = '{10'h000, 10'h000};
        tbl[5] = '{10'h200, 10'h200};
        tbl[6] = '{10'h001, 10'h001};
        tbl[7] = '{10'h155, 10'h155};

        // Reset state.
        #12;
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_sr_cp", a_cp, 0);
        check("rst_sr_data", a_sd, 0);
        check("rst_sr_e", a_e, 0);
        check("rst_err", a_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", a_ready, 1);
        check("post_rst_sr_e", a_e, 0);

        // Cascade: 20 bits, DIV=1, done at T+41.
        b_valid = 1'b1;
        b_data  = 20'hABCDE;
        k = 0;
        while (!b_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        p0 = b_pulses;
        @(negedge clk);
        b_valid = 1'b0;
        k = 0;
        for (int n = 1; n <= 60; n++) begin
            if (b_done && k == 0) k = n;
            if (n < 60) @(negedge clk);
        end
        check("cascade_done_cycle", k, 41);
        check("cascade_word", {b_q2, b_q1}, 20'hABCDE);
        check("cascade_pulses", b_pulses - p0, 20);
        check("cascade_err", b_err, 0);
        check("cascade_sr_e", b_e, 1);

        // Table-driven loads (includes the clean 1C3 / 0F0 loopback pair).
        for (int i = 0; i < 8; i++) begin
            load_a(tbl[i].word);
            check("tbl_word", a_q, tbl[i].exp_q);
        end

        // Randomised loads.
        for (int i = 0; i < 12; i++) begin
            r_w = 10'($urandom_range(0, 1023));
            load_a(r_w);
        end

        // Back-to-back with wr_valid held high.
        @(negedge clk);
        start_a(10'h3FF, 1'b1);
        a_data = 10'h000;
        finish_a(10'h3FF);
        p0 = a_pulses;
        @(negedge clk);
        check("b2b_ready_after_fin", a_ready, 1);
        check("b2b_busy_after_fin", a_busy, 0);
        check("b2b_cp_gap", a_cp, 0);
        @(negedge clk);
        a_valid = 1'b0;
        check("b2b_second_accept", a_busy, 1);
        check("b2b_no_pulse_between", a_pulses - p0, 0);
        finish_a(10'h000);

        // Loopback fault: serial return forced high after loading 000.
        load_a(10'h000);
        a_force = 1'b1;
        load_a(10'h2A5);
        a_force = 1'b0;
        load_a(10'h0F0);
        load_a(10'h1C3);
        check("fault_err_sticky", a_err, LB ? 1 : 0);

        // Reset mid-load after pulse 5.
        @(negedge clk);
        w_mid   = 10'h2A5;
        old_mid = a_q;
        p0      = a_pulses;
        start_a(w_mid, 1'b0);
        k = 0;
        while (!((a_pulses - p0) == 5 && !a_cp) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("midload_pulse5", a_pulses - p0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sr_cp", a_cp, 0);
        check("midrst_sr_e", a_e, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        check("midrst_err", a_err, 0);
        check("midrst_sr_data", a_sd, 0);
        check("midrst_ready", a_ready, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        a_shadow  = '0;
        a_err_exp = 1'b0;
        @(negedge clk);
        check("post_midrst_ready", a_ready, 1);
        check("post_midrst_busy", a_busy, 0);
        check("partial_word_kept", a_q, {old_mid[4:0], w_mid[9:5]});
        load_a(10'h155);
        check("after_abort_word", a_q, 10'h155);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
